// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. It holds one decoded instruction, forwards operands from EX/MEM and MEM/WB,
// and inserts a single bubble when a held load feeds the next instruction.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [REG_W-1:0]  inRs,
  input  logic [REG_W-1:0]  inRt,
  input  logic [REG_W-1:0]  inRd,
  input  logic [DATA_W-1:0] inRegData1,
  input  logic [DATA_W-1:0] inRegData2,
  input  logic [DATA_W-1:0] inImm,
  input  logic              inAluSrc,
  input  logic [1:0]        inAluCtrl,
  input  logic [3:0]        inCtrl,
  input  logic              exMemRegWrite,
  input  logic [REG_W-1:0]  exMemRd,
  input  logic [DATA_W-1:0] exMemResult,
  input  logic              memWbRegWrite,
  input  logic [REG_W-1:0]  memWbRd,
  input  logic [DATA_W-1:0] memWbResult,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [1:0]        aluCtrl,
  output logic [DATA_W-1:0] storeData,
  output logic [REG_W-1:0]  outRd,
  output logic [3:0]        outCtrl,
  output logic              loadUseStall
);

  // Handshake: a transfer in happens on inValid & inReady; a transfer out on outValid & outReady.
  logic              valid_q;
  logic [REG_W-1:0]  rs_q, rt_q, rd_q;
  logic [DATA_W-1:0] data1_q, data2_q, imm_q;
  logic              alu_src_q;
  logic [1:0]        alu_ctrl_q;
  logic [3:0]        ctrl_q;

  logic              advance;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  // ctrl layout is {regWrite, memRead, memWrite, memToReg}
  assign advance      = !valid_q || outReady;
  assign loadUseStall = valid_q && ctrl_q[2] && ctrl_q[3] && (rd_q != '0) &&
                        ((rd_q == inRs) || (!inAluSrc && (rd_q == inRt)));
  assign inReady      = advance && !loadUseStall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      imm_q      <= '0;
      alu_src_q  <= 1'b0;
      alu_ctrl_q <= '0;
      ctrl_q     <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (advance && loadUseStall) begin
      valid_q <= 1'b0;
    end else if (advance) begin
      valid_q    <= inValid;
      rs_q       <= inRs;
      rt_q       <= inRt;
      rd_q       <= inRd;
      data1_q    <= inRegData1;
      data2_q    <= inRegData2;
      imm_q      <= inImm;
      alu_src_q  <= inAluSrc;
      alu_ctrl_q <= inAluCtrl;
      ctrl_q     <= inCtrl;
    end else begin
      // A stalled entry outlives its producer; capture the writeback before it leaves MEM/WB.
      if (memWbRegWrite && (memWbRd != '0) && (memWbRd == rs_q)) data1_q <= memWbResult;
      if (memWbRegWrite && (memWbRd != '0) && (memWbRd == rt_q)) data2_q <= memWbResult;
    end
  end

  always_comb begin
    fwd_a = data1_q;
    if (exMemRegWrite && (exMemRd != '0) && (exMemRd == rs_q))
      fwd_a = exMemResult;
    else if (memWbRegWrite && (memWbRd != '0) && (memWbRd == rs_q))
      fwd_a = memWbResult;

    fwd_b = data2_q;
    if (exMemRegWrite && (exMemRd != '0) && (exMemRd == rt_q))
      fwd_b = exMemResult;
    else if (memWbRegWrite && (memWbRd != '0) && (memWbRd == rt_q))
      fwd_b = memWbResult;
  end

  assign outValid  = valid_q;
  assign op1       = fwd_a;
  assign op2       = alu_src_q ? imm_q : fwd_b;
  assign storeData = fwd_b;
  assign aluCtrl   = alu_ctrl_q;
  assign outRd     = rd_q;
  assign outCtrl   = ctrl_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage that registers decoded instructions and drives the exec-stage ALU operands (op1, op2, aluCtrl).
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Inserts one bubble on a load-use dependency.
- Supports valid/ready back-pressure and a synchronous flush.

Parameters:
DATA_W, 32, operand/result width
REG_W, 5, register-address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of held instruction and incoming one
inValid  in  1  decode presents an instruction
inReady  out  1  stage accepts this cycle
inRs  in  REG_W  source register A
inRt  in  REG_W  source register B
inRd  in  REG_W  destination register
inRegData1  in  DATA_W  regfile value of rs
inRegData2  in  DATA_W  regfile value of rt
inImm  in  DATA_W  sign-extended immediate
inAluSrc  in  1  1: op2 = immediate
inAluCtrl  in  2  00 add, 10 sub, 01 mul
inCtrl  in  4  {regWrite, memRead, memWrite, memToReg}
exMemRegWrite  in  1  EX/MEM writes a register
exMemRd  in  REG_W  EX/MEM destination
exMemResult  in  DATA_W  EX/MEM ALU result
memWbRegWrite  in  1  MEM/WB writes a register
memWbRd  in  REG_W  MEM/WB destination
memWbResult  in  DATA_W  MEM/WB writeback value
outValid  out  1  stage holds a valid instruction
outReady  in  1  exec/EX-MEM consumes this cycle
op1  out  DATA_W  ALU operand 1 (forwarded rs)
op2  out  DATA_W  ALU operand 2 (immediate or forwarded rt)
aluCtrl  out  2  registered inAluCtrl
storeData  out  DATA_W  forwarded rt, for stores
outRd  out  REG_W  registered inRd
outCtrl  out  4  registered inCtrl
loadUseStall  out  1  load-use hazard detected (combinational)

Behaviour:
Reset:
- rst_n low → outValid=0 and all held fields 0, asynchronously.
- Outputs read 0 during reset: op1=op2=storeData=0, aluCtrl=0, outRd=0, outCtrl=0.

Occupancy:
- The stage holds one entry, tracked by outValid.
- advance = !outValid | outReady.
- loadUseStall = outValid & outCtrl.memRead & outCtrl.regWrite & outRd!=0 & (outRd==inRs | (!inAluSrc & outRd==inRt)).
- inReady = advance & !loadUseStall & !flush.

Update priority each cycle:
1. flush → outValid=0. The incoming instruction is dropped even if inValid.
2. Else if advance & loadUseStall → outValid=0 (bubble). Decode holds its instruction.
3. Else if advance → outValid=inValid and all fields load from inputs. Load-use latency is exactly one bubble when downstream never stalls.
4. Else (held): fields keep their value, with one exception. If memWbRegWrite & memWbRd!=0 and memWbRd equals held rs (or rt), the held regData1 (or regData2) is overwritten with memWbResult. This keeps a held operand correct after its producer retires.

Forwarding (combinational on held fields):
- fwdA = held regData1, unless a match below selects another source.
- Match condition for a stage: RegWrite & Rd!=0 & Rd==held rs.
- If EX/MEM matches → exMemResult. Else if MEM/WB matches → memWbResult.
- EX/MEM wins when both match.
- fwdB uses the same rules on held rt.
- Register 0 is never forwarded.

Output mapping:
- op1 = fwdA.
- op2 = held aluSrc ? held imm : fwdB.
- storeData = fwdB.
- When outValid=0, outputs carry stale values; downstream must qualify them with outValid.

Width: all data paths are DATA_W wide with no truncation or extension; the immediate arrives pre-extended.

Test Plan:
- Reset mid-operation: holding valid add, assert rst_n=0 → outValid=0, op1=op2=0 immediately (before next clk edge).
- EX/MEM forward: held rs=3, inRegData1 was 5; exMemRegWrite=1, exMemRd=3, exMemResult=0x10 → op1=0x10.
- Priority and r0: both EX/MEM (0xAA) and MEM/WB (0xBB) target rs=7 → op1=0xAA; repeat with rs=0, regData1=0 → op1=0.
- Load-use: held lw writing r4; decode presents add rs=4 → loadUseStall=1, inReady=0, next cycle outValid=0; the following cycle the add is accepted and op1 takes memWbResult=0x1234 forwarded for r4.
- Back-pressure refresh: outReady=0 for 3 cycles holding rt=9, aluSrc=0; MEM/WB writes r9=0x55 in cycle 2, then EX/MEM and MEM/WB stop matching → storeData=0x55 persists; aluSrc=1, imm=0x8 → op2=0x8.
- Flush: inValid=1 and flush=1 with stage full → next cycle outValid=0, inReady was 0, and the new instruction never appears at the outputs.
